// File: rtl/ber_monitor_pkg.sv
// Shared types and constants for the bit-error-rate monitor.
package ber_monitor_pkg;

  // Default widths for the window/word counters and the bit-error accumulator.
  localparam int WIN_W_DEF = 32;
  localparam int ACC_W_DEF = 40;

  // Per-word error count width, shared with the PRBS7 checker upstream.
  localparam int ERR_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/sat_accum.sv
// Saturating accumulator register with synchronous clear and enable.
module sat_accum #(
  parameter int W    = 8,
  parameter int IN_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [IN_W-1:0] i_inc,
  output logic [W-1:0]    o_q
);

  logic [W-1:0] r_q;

  // Add with one guard bit; a carry out pins the result at all-ones.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [IN_W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + (W+1)'(b);
    return s[W] ? {W{1'b1}} : s[W-1:0];
  endfunction

  // Accumulator register: clear wins over accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_en)  r_q <= sat_add(r_q, i_inc);
  end

  assign o_q = r_q;

endmodule

// File: rtl/ber_monitor.sv
// Bit-error-rate monitor: accumulates PRBS7 error statistics from the word
// aligner over a programmable window, with a start/done handshake.
module ber_monitor
  import ber_monitor_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             aligned,
  input  logic [ERR_W-1:0] errorCount,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] windowWords,
  output logic             busy,
  output logic             done,
  output logic             lockLost,
  output logic [WIN_W-1:0] wordCount,
  output logic [WIN_W-1:0] errWords,
  output logic [ACC_W-1:0] bitErrors,
  output logic [ERR_W-1:0] maxBurst,
  output logic [1:0]       state
);

  state_t             r_state;
  state_t             w_next;
  logic [WIN_W-1:0]   r_limit;
  logic               r_lock_lost;
  logic [ERR_W-1:0]   r_max;
  logic               r_busy;
  logic               r_done;

  logic               w_clr;
  logic               w_acc;
  logic               w_lost;
  logic [WIN_W-1:0]   w_word_inc;
  logic               w_word_err;

  assign w_word_inc = wordCount + 1'b1;
  assign w_word_err = |errorCount;

  // Next-state and per-cycle control decode; abort always beats start.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_acc  = 1'b0;
    w_lost = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          w_clr  = 1'b1;
          w_next = ST_ARM;
        end
      end
      ST_ARM: begin
        if (abort)        w_next = ST_IDLE;
        else if (aligned) w_next = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (!aligned) begin
          w_next = ST_DONE;
          w_lost = 1'b1;
        end else begin
          w_acc = 1'b1;
          // A zero limit means free-run, which stops only when the word counter is full.
          if ((r_limit != '0) ? (w_word_inc == r_limit) : (&w_word_inc))
            w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, latched window limit, lock-loss flag, worst word and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_limit     <= '0;
      r_lock_lost <= 1'b0;
      r_max       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ST_ARM) || (w_next == ST_MEASURE);
      r_done  <= (w_next == ST_DONE);
      if (w_clr) begin
        r_limit     <= windowWords;
        r_lock_lost <= 1'b0;
        r_max       <= '0;
      end else begin
        if (w_lost)                          r_lock_lost <= 1'b1;
        if (w_acc && (errorCount > r_max))   r_max       <= errorCount;
      end
    end
  end

  sat_accum #(.W(ACC_W), .IN_W(ERR_W)) u_bit_errors (
    .clk(clk), .rst(reset), .i_clr(w_clr), .i_en(w_acc),
    .i_inc(errorCount), .o_q(bitErrors)
  );

  sat_accum #(.W(WIN_W), .IN_W(1)) u_word_count (
    .clk(clk), .rst(reset), .i_clr(w_clr), .i_en(w_acc),
    .i_inc(1'b1), .o_q(wordCount)
  );

  sat_accum #(.W(WIN_W), .IN_W(1)) u_err_words (
    .clk(clk), .rst(reset), .i_clr(w_clr), .i_en(w_acc),
    .i_inc(w_word_err), .o_q(errWords)
  );

  assign state    = r_state;
  assign busy     = r_busy;
  assign done     = r_done;
  assign lockLost = r_lock_lost;
  assign maxBurst = r_max;

endmodule

// File: tb/tb_ber_monitor.sv
// Scoreboard bench for ber_monitor: expected results are queued when a
// measurement is started and checked when done rises.
module tb_ber_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        aligned = 1'b0;
  logic [5:0]  errorCount = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] windowWords = '0;

  logic        busy, done, lockLost;
  logic [31:0] wordCount, errWords;
  logic [39:0] bitErrors;
  logic [5:0]  maxBurst;
  logic [1:0]  state;

  logic        busy8, done8, lockLost8;
  logic [31:0] wordCount8, errWords8;
  logic [7:0]  bitErrors8;
  logic [5:0]  maxBurst8;
  logic [1:0]  state8;

  ber_monitor #(.WIN_W(32), .ACC_W(40)) dut (
    .clk(clk), .reset(reset), .aligned(aligned), .errorCount(errorCount),
    .start(start), .abort(abort), .windowWords(windowWords),
    .busy(busy), .done(done), .lockLost(lockLost), .wordCount(wordCount),
    .errWords(errWords), .bitErrors(bitErrors), .maxBurst(maxBurst), .state(state)
  );

  ber_monitor #(.WIN_W(32), .ACC_W(8)) dut8 (
    .clk(clk), .reset(reset), .aligned(aligned), .errorCount(errorCount),
    .start(start), .abort(abort), .windowWords(windowWords),
    .busy(busy8), .done(done8), .lockLost(lockLost8), .wordCount(wordCount8),
    .errWords(errWords8), .bitErrors(bitErrors8), .maxBurst(maxBurst8), .state(state8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wc;
    logic [31:0] ew;
    logic [39:0] be;
    logic [5:0]  mb;
    logic        ll;
  } exp_t;

  exp_t       sbq[$];
  logic [5:0] errq[$];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int wc, input int ew, input int be, input int mb, input bit ll);
    exp_t e;
    e.wc = 32'(wc); e.ew = 32'(ew); e.be = 40'(be); e.mb = 6'(mb); e.ll = ll;
    sbq.push_back(e);
  endtask

  // Monitor: on every rising edge of done, compare results against the queue head.
  logic prev_done = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (done && !prev_done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_wordCount", 64'(wordCount), 64'(e.wc));
        chk("sb_errWords",  64'(errWords),  64'(e.ew));
        chk("sb_bitErrors", 64'(bitErrors), 64'(e.be));
        chk("sb_maxBurst",  64'(maxBurst),  64'(e.mb));
        chk("sb_lockLost",  64'(lockLost),  64'(e.ll));
        chk("sb_busy_low",  64'(busy),      64'(0));
      end
    end
    prev_done = done;
  end

  // Start a window of L words with aligned high, feeding errq then zeros.
  task automatic run_window(input int L);
    windowWords = 32'(L);
    start = 1'b1;
    aligned = 1'b1;
    tick();
    start = 1'b0;
    windowWords = 32'd3;  // must not affect the latched limit
    chk("arm_state", 64'(state), 64'(1));
    chk("arm_busy", 64'(busy), 64'(1));
    tick();
    chk("measure_state", 64'(state), 64'(2));
    for (int k = 0; k < L; k++) begin
      errorCount = (errq.size() != 0) ? errq.pop_front() : 6'd0;
      tick();
      if (k == L - 2) chk("done_not_early", 64'(done), 64'(0));
    end
    errorCount = '0;
    chk("done_at_L_plus_1", 64'(done), 64'(1));
    chk("done_state", 64'(state), 64'(3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_wordCount", 64'(wordCount), 64'(0));
    chk("rst_bitErrors", 64'(bitErrors), 64'(0));
    reset = 1'b0;
    tick();

    // 100-word error-free window
    push_exp(100, 0, 0, 0, 1'b0);
    run_window(100);
    tick();

    // 10-word window with errors 0,3,0,32,1,0,0,0,0,5 -> sum 41, 4 errored, max 32
    push_exp(10, 4, 41, 32, 1'b0);
    errq = '{6'd0, 6'd3, 6'd0, 6'd32, 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 6'd5};
    run_window(10);
    chk("acc8_small_sum", 64'(bitErrors8), 64'(41));
    tick();

    // Unaligned for 5 cycles stays in ARM, then a 4-word window
    push_exp(4, 0, 0, 0, 1'b0);
    windowWords = 32'd4;
    aligned = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("arm_hold", 64'(state), 64'(1));
    end
    aligned = 1'b1;
    tick();
    chk("arm_to_measure", 64'(state), 64'(2));
    for (int k = 0; k < 4; k++) tick();
    chk("win4_done", 64'(done), 64'(1));
    tick();

    // 50-word window, lock drops after 20 samples of errorCount=1
    push_exp(20, 20, 20, 1, 1'b1);
    windowWords = 32'd50;
    aligned = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    errorCount = 6'd1;
    tick();
    for (int k = 0; k < 20; k++) tick();
    aligned = 1'b0;
    tick();
    chk("lock_loss_state", 64'(state), 64'(3));
    chk("lock_loss_wc", 64'(wordCount), 64'(20));
    errorCount = '0;
    tick();
    chk("done_ignores_abort_prep", 64'(state), 64'(3));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_lockLost", 64'(lockLost), 64'(0));
    chk("restart_state", 64'(state), 64'(1));
    chk("restart_done", 64'(done), 64'(0));
    chk("restart_wc_clear", 64'(wordCount), 64'(0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_arm", 64'(state), 64'(0));

    // Free-run with errorCount=32: 8-bit accumulator saturates, 40-bit does not
    windowWords = 32'd0;
    aligned = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    errorCount = 6'd32;
    for (int k = 0; k < 10; k++) tick();
    chk("freerun_wc", 64'(wordCount), 64'(10));
    chk("freerun_be40", 64'(bitErrors), 64'(320));
    chk("sat_be8", 64'(bitErrors8), 64'(255));
    chk("freerun_state", 64'(state), 64'(2));
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    errorCount = '0;
    chk("abort_wins_state", 64'(state), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hold_be", 64'(bitErrors), 64'(320));
    chk("abort_hold_be8", 64'(bitErrors8), 64'(255));
    tick();

    // Asynchronous reset in the middle of a measurement
    windowWords = 32'd30;
    start = 1'b1;
    tick();
    start = 1'b0;
    errorCount = 6'd4;
    for (int k = 0; k < 6; k++) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 64'(state), 64'(0));
    chk("async_rst_wc", 64'(wordCount), 64'(0));
    chk("async_rst_be", 64'(bitErrors), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    errorCount = '0;
    tick();

    // Normal operation after reset release: errors 2,0,7
    push_exp(3, 2, 9, 7, 1'b0);
    errq = '{6'd2, 6'd0, 6'd7};
    run_window(3);
    tick();
    tick();

    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
